// File: rtl/debounce.sv
// Per-bit counter debouncer for level inputs that are already in the clk domain.
// o[n] follows i[n] only after DEBOUNCE consecutive ticks that sample a difference.
module debounce #(
    parameter int DATAWIDTH = 1,
    parameter int DEBOUNCE  = 4,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 tick,
    input  logic [DATAWIDTH-1:0] i,
    output logic [DATAWIDTH-1:0] o,
    output logic [DATAWIDTH-1:0] rise,
    output logic [DATAWIDTH-1:0] fall,
    output logic                 changed,
    output logic                 busy
);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } bit_state_t;

    localparam logic [CNTWIDTH-1:0] CNT_LAST = CNTWIDTH'(DEBOUNCE - 1);
    localparam logic [CNTWIDTH-1:0] CNT_ONE  = CNTWIDTH'(1);

    logic [CNTWIDTH-1:0]  cnt      [DATAWIDTH];
    logic [CNTWIDTH-1:0]  cnt_nxt  [DATAWIDTH];
    logic [DATAWIDTH-1:0] o_nxt;
    logic [DATAWIDTH-1:0] rise_nxt;
    logic [DATAWIDTH-1:0] fall_nxt;
    bit_state_t           state    [DATAWIDTH];

    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        o_nxt    = o;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int n = 0; n < DATAWIDTH; n++) begin
            cnt_nxt[n] = cnt[n];
            if (tick) begin
                if (i[n] == o[n]) begin
                    // A matching sample aborts the run; the count restarts from zero.
                    cnt_nxt[n] = '0;
                end else if (cnt[n] == CNT_LAST) begin
                    o_nxt[n]    = i[n];
                    cnt_nxt[n]  = '0;
                    rise_nxt[n] = i[n];
                    fall_nxt[n] = ~i[n];
                end else begin
                    cnt_nxt[n] = cnt[n] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int n = 0; n < DATAWIDTH; n++) begin
            state[n] = (cnt[n] != '0) ? SETTLING : STABLE;
            if (state[n] == SETTLING) begin
                busy = 1'b1;
            end
        end
    end

    // NOTE: the per-bit counter array is reset along with the outputs so a partial count never survives reset.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int n = 0; n < DATAWIDTH; n++) begin
                cnt[n] <= '0;
            end
            o       <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int n = 0; n < DATAWIDTH; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
            o       <= o_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            changed <= |(rise_nxt | fall_nxt);
        end
    end

endmodule
